// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the program counter, drives the ROM address,
// registers the fetched word into IF/ID and applies decode-stage redirects.
module fetch_stage #(
    parameter int D       = 12,
    parameter int W       = 9,
    parameter int HALT_PC = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         reljump_en,
    input  logic         absjump_en,
    input  logic [D-1:0] target,
    output logic [D-1:0] rom_addr,
    input  logic [W-1:0] rom_data,
    output logic [W-1:0] instr,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    output logic         done
);

    localparam logic [D-1:0] HALT_ADDR = D'(HALT_PC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t         state_reg, state_next;
    logic [D-1:0]   pc_reg, pc_next;
    logic [W-1:0]   instr_reg, instr_next;
    logic [D-1:0]   instr_pc_reg, instr_pc_next;
    logic           instr_valid_reg, instr_valid_next;
    logic           done_reg, done_next;
    logic [D-1:0]   jump_target;
    logic           redirect;

    // Relative offsets are taken from the jump instruction's own address.
    assign jump_target = absjump_en ? target : (instr_pc_reg + target);
    assign redirect    = instr_valid_reg && (reljump_en || absjump_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        done_next        = done_reg;

        case (state_reg)
            IDLE: begin
                pc_next          = '0;
                instr_valid_next = 1'b0;
                if (req) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        // The word fetched this cycle is on the wrong path.
                        pc_next          = jump_target;
                        instr_next       = rom_data;
                        instr_pc_next    = pc_reg;
                        instr_valid_next = 1'b0;
                    end else if (pc_reg == HALT_ADDR) begin
                        state_next       = HALT;
                        done_next        = 1'b1;
                        instr_valid_next = 1'b0;
                    end else begin
                        instr_next       = rom_data;
                        instr_pc_next    = pc_reg;
                        instr_valid_next = 1'b1;
                        pc_next          = pc_reg + 1'b1;
                    end
                end
            end
            HALT: begin
                instr_valid_next = 1'b0;
                if (req) begin
                    pc_next    = '0;
                    done_next  = 1'b0;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rom_addr    = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue of expected instr_pc values is filled as
// stimulus is driven and drained whenever the stage presents a valid instruction.
module tb_fetch_stage;

    localparam int D = 12;
    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         req;
    logic         stall;
    logic         reljump_en;
    logic         absjump_en;
    logic [D-1:0] target;
    logic [D-1:0] rom_addr;
    logic [W-1:0] rom_data;
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         done;

    int           n_cmp;
    int           n_err;
    logic [D-1:0] sb[$];

    fetch_stage #(.D(D), .W(W), .HALT_PC(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .reljump_en (reljump_en),
        .absjump_en (absjump_en),
        .target     (target),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .done       (done)
    );

    // ROM[k] = k
    assign rom_data = rom_addr[W-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_raw();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and retire any valid instruction against the scoreboard.
    task automatic tick();
        logic [D-1:0] exp_pc;
        logic [W-1:0] exp_word;
        tick_raw();
        if (instr_valid === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_pc   = sb.pop_front();
                exp_word = exp_pc[W-1:0];
                chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
                chk("instr", 32'(instr), 32'(exp_word));
                $display("txn: instr_pc=%0d instr=%0d", instr_pc, instr);
            end
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) sb.push_back(D'(k));
    endtask

    task automatic run_until(input int pc_target, input int budget);
        int  cyc;
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < budget) begin
            tick();
            cyc++;
            hit = (instr_valid === 1'b1) && (instr_pc === D'(pc_target));
        end
        if (!hit) chk("run_until_timeout", 32'(instr_pc), 32'(pc_target));
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        req        = 1'b0;
        stall      = 1'b0;
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        target     = '0;

        // Reset state
        tick_raw();
        tick_raw();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick_raw();
        chk("idle_rom_addr", 32'(rom_addr), 32'd0);

        // Straight line 0..127 then halt
        push_range(0, 127);
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("first_cycle_no_valid", 32'(instr_valid), 32'd0);
        run_until(127, 300);
        chk("done_before_halt", 32'(done), 32'd0);
        tick();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_rom_addr", 32'(rom_addr), 32'd128);
        chk("sb_drained_line", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold_done", 32'(done), 32'd1);
            chk("halt_hold_addr", 32'(rom_addr), 32'd128);
        end

        // Restart from HALT
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_valid", 32'(instr_valid), 32'd0);
        push_range(0, 5);
        tick();
        chk("restart_first_valid", 32'(instr_valid), 32'd1);
        run_until(5, 20);

        // Stall three cycles at instr_pc=5
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_raw();
            chk("stall_instr_pc", 32'(instr_pc), 32'd5);
            chk("stall_instr", 32'(instr), 32'd5);
            chk("stall_rom_addr", 32'(rom_addr), 32'd6);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        push_range(6, 10);
        run_until(10, 20);

        // Relative jump back by 3 from instr_pc=10
        reljump_en = 1'b1;
        target     = 12'hFFD;
        tick();
        reljump_en = 1'b0;
        chk("rel_bubble", 32'(instr_valid), 32'd0);
        chk("rel_rom_addr", 32'(rom_addr), 32'd7);
        push_range(7, 9);
        run_until(9, 10);

        // Absolute beats relative
        absjump_en = 1'b1;
        reljump_en = 1'b1;
        target     = 12'h020;
        tick();
        reljump_en = 1'b0;
        chk("abs_bubble", 32'(instr_valid), 32'd0);
        chk("abs_rom_addr", 32'(rom_addr), 32'd32);
        // Jump during the bubble must be ignored
        target = 12'h050;
        push_range(32, 34);
        tick();
        absjump_en = 1'b0;
        chk("ignored_jump_addr", 32'(rom_addr), 32'd33);
        run_until(34, 10);

        // req in RUN has no effect
        push_range(35, 36);
        req = 1'b1;
        tick();
        req = 1'b0;
        run_until(36, 10);
        chk("sb_drained_run", 32'(sb.size()), 32'd0);
        chk("pre_reset_addr", 32'(rom_addr), 32'd37);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_addr", 32'(rom_addr), 32'd0);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_instr", 32'(instr), 32'd0);
        reset = 1'b1;
        req   = 1'b1;
        tick();
        req = 1'b0;
        push_range(0, 3);
        run_until(3, 10);

        // Redirect straight onto HALT_PC, stalled on the halt cycle
        absjump_en = 1'b1;
        target     = 12'd128;
        tick();
        absjump_en = 1'b0;
        chk("jmp_halt_addr", 32'(rom_addr), 32'd128);
        chk("jmp_halt_done", 32'(done), 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_halt_done", 32'(done), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("final_done", 32'(done), 32'd1);
        chk("final_valid", 32'(instr_valid), 32'd0);
        chk("final_addr", 32'(rom_addr), 32'd128);
        chk("sb_drained_end", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
